// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) line arbiter onto a single handshaked memory
module mem_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [63:0] i_rdata,
  output logic        i_done,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_read_ack,
  input  logic        mem_write_ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  state_t      state;
  logic        owner_d;
  logic        we;
  logic        last_grant_d;
  logic [5:0]  cnt;
  logic        grant_d;
  logic        sel_ack;
  logic [5:0]  cnt_inc;
  logic        tmo;

  // D wins when it is alone, or when both ask and I had the last grant.
  assign grant_d = d_req && (!i_req || !last_grant_d);
  assign sel_ack = we ? mem_write_ack : mem_read_ack;
  assign cnt_inc = cnt + 6'd1;
  assign tmo     = (cnt_inc == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      we           <= 1'b0;
      last_grant_d <= 1'b0;
      cnt          <= 6'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= 16'h0;
      mem_wdata    <= 64'h0;
      i_rdata      <= 64'h0;
      d_rdata      <= 64'h0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_err        <= 1'b0;
      d_err        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d      <= grant_d;
            last_grant_d <= grant_d;
            we           <= grant_d && d_we;
            mem_addr     <= grant_d ? {d_addr[15:2], 2'b00} : {i_addr[15:2], 2'b00};
            if (grant_d)
              mem_wdata  <= d_wdata;
            mem_read     <= !(grant_d && d_we);
            mem_write    <= grant_d && d_we;
            cnt          <= 6'd0;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt_inc;
          if (tmo) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_done    <= !owner_d;
            d_done    <= owner_d;
            i_err     <= !owner_d;
            d_err     <= owner_d;
            state     <= DONE;
          end else if (!sel_ack) begin
            // an ack still high from before this request is ignored here
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          if (sel_ack) begin
            if (!we) begin
              if (owner_d)
                d_rdata <= mem_rdata;
              else
                i_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_done    <= !owner_d;
            d_done    <= owner_d;
            state     <= DONE;
          end else if (tmo) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            i_done    <= !owner_d;
            d_done    <= owner_d;
            i_err     <= !owner_d;
            d_err     <= owner_d;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter with a word-array memory model
module tb_mem_arbiter;

  logic        clk, reset_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr;
  logic [63:0] d_wdata;
  logic [63:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        i_done, i_err, d_done, d_err;
  logic        mem_read, mem_write, mem_read_ack, mem_write_ack, busy;
  logic [15:0] mem_addr;

  mem_arbiter #(.TIMEOUT(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // memory model knobs
  int lat = 4;
  int pre = 0;
  bit stuck = 0;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  // memory model: ack optionally held high for `pre` cycles, low for the rest, then high with data
  bit          stale, active, ack_val;
  int          mcnt;
  logic [15:0] mb;
  initial begin
    stale = 1; active = 0; ack_val = 1; mcnt = 0;
    mem_read_ack = 1'b1; mem_write_ack = 1'b1; mem_rdata = 64'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin
        stale = 0;
        if (!active) begin
          active = 1;
          mcnt = 0;
        end else begin
          mcnt++;
        end
        mb = mem_addr;
        if (stuck)                 ack_val = 1;
        else if (mcnt < pre)       ack_val = 1;
        else if (mcnt < pre + lat) ack_val = 0;
        else                       ack_val = 1;
        if (!stuck && mcnt == pre + lat) begin
          if (mem_write) begin
            mem[mb]         = mem_wdata[63:48];
            mem[mb + 16'd1] = mem_wdata[47:32];
            mem[mb + 16'd2] = mem_wdata[31:16];
            mem[mb + 16'd3] = mem_wdata[15:0];
          end else begin
            mem_rdata = {mem[mb], mem[mb + 16'd1], mem[mb + 16'd2], mem[mb + 16'd3]};
          end
        end
        mem_read_ack  = mem_read  ? ack_val : 1'b0;
        mem_write_ack = mem_write ? ack_val : 1'b0;
      end else begin
        active = 0;
        mem_read_ack  = stale;
        mem_write_ack = stale;
      end
    end
  end

  // reference model: serial transactions against a word array
  typedef struct {
    bit          sd;
    bit          err;
    logic [63:0] rd;
    logic [63:0] other;
  } exp_t;
  exp_t        exp_q[$];
  logic [63:0] exp_i = 64'h0;
  logic [63:0] exp_d = 64'h0;
  bit          last_d = 0;

  task automatic serve(input bit sd, input bit we, input logic [15:0] a,
                       input logic [63:0] wd, input bit err);
    exp_t        e;
    logic [15:0] b;
    logic [63:0] line;
    b = {a[15:2], 2'b00};
    e.sd = sd;
    e.err = err;
    e.other = sd ? exp_i : exp_d;
    if (!err) begin
      if (sd && we) begin
        for (int k = 0; k < 4; k++) ref_mem[b + 16'(k)] = wd[63 - 16*k -: 16];
      end else begin
        line = {ref_mem[b], ref_mem[b + 16'd1], ref_mem[b + 16'd2], ref_mem[b + 16'd3]};
        if (sd) exp_d = line; else exp_i = line;
      end
    end
    e.rd = sd ? exp_d : exp_i;
    exp_q.push_back(e);
  endtask

  // monitor: strobe sanity every cycle, completion checked against the queue
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] got, got_o;
    logic        got_err;
    if (reset_n) begin
      if (mem_read || mem_write) begin
        tests++;
        if ((mem_read && mem_write) || mem_addr[1:0] != 2'b00) begin
          failed++;
          $display("FAIL strobe: rd=%0b wr=%0b addr=%h, required one strobe and aligned addr",
                   mem_read, mem_write, mem_addr);
        end
      end
      if (i_done || d_done) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_done: i_done=%0b d_done=%0b, required none", i_done, d_done);
        end else begin
          e = exp_q.pop_front();
          got     = e.sd ? d_rdata : i_rdata;
          got_o   = e.sd ? i_rdata : d_rdata;
          got_err = e.sd ? d_err : i_err;
          if (i_done != !e.sd || d_done != e.sd || got_err != e.err || got != e.rd ||
              got_o != e.other || (e.sd ? i_err : d_err)) begin
            failed++;
            $display("FAIL completion: i_done=%0b d_done=%0b err=%0b rdata=%h other=%h, required side_d=%0b err=%0b rdata=%h other=%h",
                     i_done, d_done, got_err, got, got_o, e.sd, e.err, e.rd, e.other);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic run_one(input bit sd, input bit we, input logic [15:0] a, input logic [63:0] wd,
                         input bit err, output int ncyc, output int nstrobe, output bit saw_read,
                         output logic [15:0] maddr);
    bit seen;
    serve(sd, we, a, wd, err);
    last_d = sd;
    @(posedge clk); #1;
    if (sd) begin d_we = we; d_addr = a; d_wdata = wd; d_req = 1; end
    else    begin i_addr = a; i_req = 1; end
    ncyc = 0; nstrobe = 0; saw_read = 0; seen = 0; maddr = 16'hxxxx;
    while (!seen && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      if (mem_read || mem_write) begin nstrobe++; maddr = mem_addr; end
      if (mem_read) saw_read = 1;
      if (sd ? d_done : i_done) seen = 1;
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    if (!seen) begin
      tests++; failed++;
      $display("FAIL run_one_timeout: no done after %0d cycles, required done", ncyc);
    end
  endtask

  task automatic do_round(input int pat, input bit force_read);
    logic [15:0] ia, da;
    logic        dwe;
    logic [63:0] wd;
    bit          first_d, ip, dp, is, ds;
    int          cyc;
    ia = 16'($urandom); da = 16'($urandom); wd = {$urandom, $urandom};
    dwe = force_read ? 1'b0 : 1'($urandom_range(0, 1));
    first_d = (pat == 3) ? !last_d : (pat == 2);
    if (pat == 3) begin
      serve(first_d, first_d ? dwe : 1'b0, first_d ? da : ia, wd, 0);
      serve(!first_d, first_d ? 1'b0 : dwe, first_d ? ia : da, wd, 0);
      last_d = !first_d;
    end else begin
      serve(first_d, first_d ? dwe : 1'b0, first_d ? da : ia, wd, 0);
      last_d = first_d;
    end
    @(posedge clk); #1;
    i_addr = ia; d_addr = da; d_we = dwe; d_wdata = wd;
    i_req = pat[0]; d_req = pat[1];
    ip = pat[0]; dp = pat[1]; cyc = 0;
    while ((ip || dp) && cyc < 300) begin
      @(negedge clk);
      is = i_done; ds = d_done;
      @(posedge clk); #1;
      cyc++;
      if (is) begin i_req = 0; ip = 0; end
      if (ds) begin d_req = 0; dp = 0; end
      // the first-served side is already granted: its inputs must no longer matter
      if (cyc == 2) begin
        if (first_d) begin d_addr = 16'($urandom); d_wdata = {$urandom, $urandom}; d_we = 1'($urandom_range(0, 1)); end
        else i_addr = 16'($urandom);
      end
    end
    i_req = 0; d_req = 0;
    if (ip || dp) begin
      tests++; failed++;
      $display("FAIL round_timeout: pattern %0d still pending after %0d cycles, required completion", pat, cyc);
    end
  endtask

  initial begin
    int          ncyc, nstr, gap, ndone;
    bit          saw_rd, in_gap;
    logic [15:0] maddr;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 16'(a * 40503 + 7);
      ref_mem[a] = 16'(a * 40503 + 7);
    end
    reset_n = 0; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("reset_strobes", {62'h0, mem_read, mem_write}, 64'h0);
    check("reset_flags", {59'h0, i_done, d_done, i_err, d_err, busy}, 64'h0);
    check("reset_i_rdata", i_rdata, 64'h0);
    check("reset_d_rdata", d_rdata, 64'h0);
    check("reset_wdata_addr", mem_wdata | {48'h0, mem_addr}, 64'h0);

    // simultaneous pairs straight after reset: model predicts D first
    lat = 3; pre = 1;
    do_round(3, 1);
    do_round(3, 1);

    // single I read, exact latency and aligned address
    lat = 4; pre = 0;
    run_one(0, 0, 16'h0025, 64'h0, 0, ncyc, nstr, saw_rd, maddr);
    check("i_read_latency", 64'(ncyc), 64'd7);
    check("i_read_strobe_cycles", 64'(nstr), 64'd5);
    check("i_read_addr", {48'h0, maddr}, 64'h0024);

    // D write
    run_one(1, 1, 16'h0102, 64'h1111_2222_3333_4444, 0, ncyc, nstr, saw_rd, maddr);
    check("d_write_no_read", {63'h0, saw_rd}, 64'h0);
    check("d_write_addr", {48'h0, maddr}, 64'h0100);
    check("d_write_mem", {mem[16'h100], mem[16'h101], mem[16'h102], mem[16'h103]},
          64'h1111_2222_3333_4444);

    // ack stuck high: timeout abort
    stuck = 1;
    run_one(0, 0, 16'h0300, 64'h0, 1, ncyc, nstr, saw_rd, maddr);
    check("timeout_strobe_cycles", 64'(nstr), 64'd31);
    stuck = 0;

    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      lat = $urandom_range(1, 6);
      pre = $urandom_range(0, 2);
      do_round($urandom_range(1, 3), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // back-to-back D reads with req held across done
    lat = 4; pre = 0;
    serve(1, 0, 16'h0410, 64'h0, 0);
    serve(1, 0, 16'h0523, 64'h0, 0);
    last_d = 1;
    @(posedge clk); #1;
    d_we = 0; d_addr = 16'h0410; d_req = 1;
    ncyc = 0; ndone = 0; gap = 0; in_gap = 0;
    while (ndone < 2 && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      if (d_done) begin ndone++; in_gap = (ndone == 1); end
      if (in_gap && mem_read) in_gap = 0;
      if (in_gap && !mem_read) gap++;
      @(posedge clk); #1;
      if (ndone == 1) d_addr = 16'h0523;
    end
    d_req = 0;
    check("b2b_done_count", 64'(ndone), 64'd2);
    tests++;
    if (gap < 2) begin
      failed++;
      $display("FAIL b2b_gap: got %0d low cycles, required at least 2", gap);
    end

    // reset while in WAIT
    lat = 8; pre = 0;
    @(posedge clk); #1;
    i_addr = 16'h0777; i_req = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 0; i_req = 0;
    @(posedge clk); #1 reset_n = 1;
    exp_i = 64'h0; exp_d = 64'h0; last_d = 0;
    @(negedge clk);
    check("rst_wait_strobe", {63'h0, mem_read}, 64'h0);
    check("rst_wait_busy", {63'h0, busy}, 64'h0);
    check("rst_wait_done", {63'h0, i_done}, 64'h0);
    check("rst_wait_rdata", i_rdata, 64'h0);
    repeat (12) @(posedge clk);
    lat = 4;
    run_one(0, 0, 16'h0778, 64'h0, 0, ncyc, nstr, saw_rd, maddr);
    check("post_reset_latency", 64'(ncyc), 64'd7);

    repeat (5) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
